// File: rtl/bg_scroll_engine_pkg.sv
// Shared constants and refill request record for the background scroll engine.
package bg_scroll_engine_pkg;

    localparam int NAME_ROW_BYTES = 32;
    localparam int PAGE_BYTES     = 1024;
    localparam int ATTR_OFFSET    = 960;

    // Request fields are sized for the widest supported configuration; the top narrows them.
    localparam int REQ_ADDR_MAX_W = 32;
    localparam int REQ_PTR_MAX_W  = 16;

    typedef struct packed {
        logic                      isAttr;
        logic [REQ_ADDR_MAX_W-1:0] flashAddr;
        logic [REQ_PTR_MAX_W-1:0]  ramAddr;
    } scroll_req_t;

    localparam int REQ_W = $bits(scroll_req_t);

endpackage

// File: rtl/bg_scroll_engine_fifo.sv
// Refill request queue: power-of-two FIFO with valid/ready read side and overflow drop flag.
module scroll_req_fifo
    import bg_scroll_engine_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [REQ_W-1:0] wr_data,
    output logic             wr_drop,
    output logic             rd_valid,
    output logic [REQ_W-1:0] rd_data,
    input  logic             rd_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [REQ_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             pop;
    logic             push;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_valid = (wr_ptr != rd_ptr);
    assign pop      = rd_valid && rd_ready;
    // A read on the same edge frees the slot, so a full queue still accepts the write.
    assign push     = wr_en && (!full || pop);
    assign wr_drop  = wr_en && full && !pop;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bg_scroll_engine.sv
// Two-page vertical background scroller issuing tile-row refill requests.
// Optional SCROLL_LOOP_EN: background counter wraps to 0 past mapBackgroundMax instead of stopping.
module bg_scroll_engine
    import bg_scroll_engine_pkg::*;
#(
    parameter int PTR_W      = 9,
    parameter int PAGE_LINES = 240,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              scrollEn,
    input  logic              scrollDir,
    input  logic [7:0]        scrollCntMax,
    input  logic [ADDR_W-1:0] flashAddrStart,
    input  logic [7:0]        mapBackgroundMax,
    input  logic              vgaIntr,
    output logic [7:0]        mapBackgroundCnt,
    output logic [PTR_W-1:0]  scrollPtrOut,
    output logic [7:0]        mapScrollPtr,
    output logic              scrollingFlag,
    output logic              reqValid,
    input  logic              reqReady,
    output logic              reqIsAttr,
    output logic [ADDR_W-1:0] reqFlashAddr,
    output logic [PTR_W-1:0]  reqRamAddr,
    output logic              overrunErr
);

    localparam logic [PTR_W-1:0] HALF   = {1'b1, {(PTR_W-1){1'b0}}};
    localparam logic [PTR_W-1:0] TGT_LO = PTR_W'(PAGE_LINES - 1);
    localparam logic [PTR_W-1:0] TGT_HI = HALF + PTR_W'(PAGE_LINES - 1);

    logic             intr_q1, intr_q2, frame_pulse, step;
    logic [7:0]       frame_cnt, cnt_next;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic             wrapped, name_hit, attr_hit;
    logic [ADDR_W-1:0] name_flash, attr_flash;
    logic [PTR_W-1:0]  name_ram, attr_ram;
    scroll_req_t      name_req, attr_req, head;
    logic [REQ_W-1:0] pend_req, fifo_wr_data, fifo_rd_data;
    logic             pend_busy, fifo_wr, fifo_drop;
    logic             unused_hi;

    assign frame_pulse   = intr_q1 && !intr_q2;
    assign scrollingFlag = scrollEn && (mapBackgroundCnt <= mapBackgroundMax);
    assign step          = frame_pulse && scrollingFlag && (frame_cnt == scrollCntMax);
    assign mapScrollPtr  = ptr[7:0];

    always_comb begin
        ptr_next = ptr;
        cnt_next = mapBackgroundCnt;
        wrapped  = 1'b0;
        if (scrollDir) begin
            if (ptr == TGT_LO) begin
                ptr_next = HALF;
                wrapped  = 1'b1;
            end else if (ptr == TGT_HI) begin
                ptr_next = '0;
                wrapped  = 1'b1;
            end else begin
                ptr_next = ptr + 1'b1;
            end
            if (wrapped && mapBackgroundCnt != 8'd0) cnt_next = mapBackgroundCnt - 1'b1;
        end else begin
            if (ptr == HALF) begin
                ptr_next = TGT_LO;
                wrapped  = 1'b1;
            end else if (ptr == '0) begin
                ptr_next = TGT_HI;
                wrapped  = 1'b1;
            end else begin
                ptr_next = ptr - 1'b1;
            end
`ifdef SCROLL_LOOP_EN
            if (wrapped) cnt_next = (mapBackgroundCnt >= mapBackgroundMax) ? 8'd0 : mapBackgroundCnt + 1'b1;
`else
            if (wrapped) cnt_next = mapBackgroundCnt + 1'b1;
`endif
        end
        name_hit = scrollDir ? (ptr_next[2:0] == 3'd0) : (ptr_next[2:0] == 3'd7);
        attr_hit = name_hit && (wrapped || (scrollDir ? (ptr_next[4:0] == 5'd0) : (ptr_next[4:0] == 5'd31)));
    end

    always_comb begin
        name_flash = flashAddrStart + ADDR_W'(cnt_next) * ADDR_W'(PAGE_BYTES)
                   + ADDR_W'(ptr_next[7:3]) * ADDR_W'(NAME_ROW_BYTES);
        attr_flash = flashAddrStart + ADDR_W'(cnt_next) * ADDR_W'(PAGE_BYTES)
                   + ADDR_W'(ATTR_OFFSET) + ADDR_W'({ptr_next[7:5], 3'b000});
        name_ram   = {ptr_next[PTR_W-1:3], 3'b000};
        attr_ram   = {ptr_next[PTR_W-1], {(PTR_W-1){1'b0}}} + PTR_W'(PAGE_LINES)
                   + PTR_W'({ptr_next[7:5], 1'b0});
        name_req.isAttr    = 1'b0;
        name_req.flashAddr = REQ_ADDR_MAX_W'(name_flash);
        name_req.ramAddr   = REQ_PTR_MAX_W'(name_ram);
        attr_req.isAttr    = 1'b1;
        attr_req.flashAddr = REQ_ADDR_MAX_W'(attr_flash);
        attr_req.ramAddr   = REQ_PTR_MAX_W'(attr_ram);
    end

    // The held attribute request goes out the cycle after its name request; a new step then loses its requests.
    assign fifo_wr      = pend_busy || (step && name_hit);
    assign fifo_wr_data = pend_busy ? pend_req : name_req;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            intr_q1 <= 1'b0; intr_q2 <= 1'b0;
            frame_cnt <= '0; ptr <= '0; scrollPtrOut <= '0; mapBackgroundCnt <= '0;
            pend_busy <= 1'b0; pend_req <= '0; overrunErr <= 1'b0;
        end else if (!scrollEn) begin
            intr_q1 <= 1'b0; intr_q2 <= 1'b0;
            frame_cnt <= '0; ptr <= '0; scrollPtrOut <= '0; mapBackgroundCnt <= '0;
            pend_busy <= 1'b0; pend_req <= '0; overrunErr <= 1'b0;
        end else begin
            intr_q1 <= vgaIntr;
            intr_q2 <= intr_q1;
            if (step) begin
                ptr              <= ptr_next;
                scrollPtrOut     <= ptr;
                mapBackgroundCnt <= cnt_next;
                frame_cnt        <= '0;
            end else if (frame_pulse && scrollingFlag) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            pend_busy <= step && !pend_busy && attr_hit;
            if (step && !pend_busy) pend_req <= attr_req;
            if (fifo_drop || (step && pend_busy)) overrunErr <= 1'b1;
        end
    end

    scroll_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (!scrollEn),
        .wr_en    (fifo_wr),
        .wr_data  (fifo_wr_data),
        .wr_drop  (fifo_drop),
        .rd_valid (reqValid),
        .rd_data  (fifo_rd_data),
        .rd_ready (reqReady)
    );

    assign head         = fifo_rd_data;
    assign reqIsAttr    = head.isAttr;
    assign reqFlashAddr = head.flashAddr[ADDR_W-1:0];
    assign reqRamAddr   = head.ramAddr[PTR_W-1:0];
    assign unused_hi    = |{head.flashAddr, head.ramAddr};

endmodule

// File: tb/tb_bg_scroll_engine.sv
// Directed bench for bg_scroll_engine; refill requests are checked by a queue-based scoreboard.
module tb_bg_scroll_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic        scrollEn, scrollDir, vgaIntr, reqReady;
    logic [7:0]  scrollCntMax, mapBackgroundMax;
    logic [23:0] flashAddrStart;
    logic [7:0]  mapBackgroundCnt, mapScrollPtr;
    logic [8:0]  scrollPtrOut, reqRamAddr;
    logic        scrollingFlag, reqValid, reqIsAttr, overrunErr;
    logic [23:0] reqFlashAddr;

    typedef struct {
        logic        isAttr;
        logic [23:0] flash;
        logic [8:0]  ram;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   sb_mute = 1'b0;

    localparam logic [23:0] S = 24'h100000;

    always #5 clk = ~clk;

    bg_scroll_engine #(.PTR_W(9), .PAGE_LINES(240), .FIFO_DEPTH(2), .ADDR_W(24)) dut (
        .clk(clk), .rstn(rstn), .scrollEn(scrollEn), .scrollDir(scrollDir),
        .scrollCntMax(scrollCntMax), .flashAddrStart(flashAddrStart),
        .mapBackgroundMax(mapBackgroundMax), .vgaIntr(vgaIntr),
        .mapBackgroundCnt(mapBackgroundCnt), .scrollPtrOut(scrollPtrOut),
        .mapScrollPtr(mapScrollPtr), .scrollingFlag(scrollingFlag),
        .reqValid(reqValid), .reqReady(reqReady), .reqIsAttr(reqIsAttr),
        .reqFlashAddr(reqFlashAddr), .reqRamAddr(reqRamAddr), .overrunErr(overrunErr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int hold);
        vgaIntr = 1'b1;
        tick(hold);
        vgaIntr = 1'b0;
        tick(4);
    endtask

    task automatic expect_req(input logic a, input logic [23:0] f, input logic [8:0] r);
        exp_t e;
        e.isAttr = a; e.flash = f; e.ram = r;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        chk("sb_drain", sbq.size(), 0);
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (reqValid && reqReady && !sb_mute) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: got attr=%0d flash=0x%0h ram=%0d, required no request",
                         reqIsAttr, reqFlashAddr, reqRamAddr);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("req_isAttr", reqIsAttr, e.isAttr);
                chk("req_flash",  reqFlashAddr, e.flash);
                chk("req_ram",    reqRamAddr, e.ram);
            end
        end
    end

    initial begin
        rstn = 1'b0; scrollEn = 1'b0; scrollDir = 1'b0; vgaIntr = 1'b0; reqReady = 1'b1;
        scrollCntMax = 8'd0; mapBackgroundMax = 8'd10; flashAddrStart = S;
        tick(3);
        chk("rst_ptr", mapScrollPtr, 0);
        chk("rst_ptrout", scrollPtrOut, 0);
        chk("rst_cnt", mapBackgroundCnt, 0);
        chk("rst_valid", reqValid, 0);
        chk("rst_overrun", overrunErr, 0);
        chk("rst_flag", scrollingFlag, 0);
        rstn = 1'b1; tick(1);
        scrollEn = 1'b1; tick(1);
        chk("flag_on", scrollingFlag, 1);

        // Down from reset: wrap 0 -> 495 then linear decrement
        expect_req(1'b0, S + 24'd1024 + 24'd928, 9'd488);
        expect_req(1'b1, S + 24'd1024 + 24'd960 + 24'd56, 9'd510);
        for (int i = 0; i < 8; i++) begin
            frame(3);
            chk("dn_ptr", mapScrollPtr, 239 - i);
            chk("dn_ptrout", scrollPtrOut, (i == 0) ? 0 : 496 - i);
        end
        chk("dn_cnt", mapBackgroundCnt, 1);
        drain();

        // Four frames per step; a long interrupt level counts once
        scrollCntMax = 8'd3;
        for (int i = 0; i < 3; i++) frame(10);
        chk("div_hold", mapScrollPtr, 232);
        expect_req(1'b0, S + 24'd1024 + 24'd896, 9'd480);
        frame(10);
        chk("div_step", mapScrollPtr, 231);
        chk("div_ptrout", scrollPtrOut, 488);
        drain();

        // Synchronous clear, then up-direction wraps
        scrollCntMax = 8'd0;
        scrollEn = 1'b0; tick(1);
        chk("clr_ptr", mapScrollPtr, 0);
        chk("clr_cnt", mapBackgroundCnt, 0);
        scrollEn = 1'b1; tick(1);
        expect_req(1'b0, S + 24'd1024 + 24'd928, 9'd488);
        expect_req(1'b1, S + 24'd2040, 9'd510);
        frame(3);
        chk("re_cnt", mapBackgroundCnt, 1);
        drain();
        scrollDir = 1'b1;
        expect_req(1'b0, S, 9'd0);
        expect_req(1'b1, S + 24'd960, 9'd240);
        frame(3);
        chk("up_wrap_ptr", mapScrollPtr, 0);
        chk("up_wrap_ptrout", scrollPtrOut, 495);
        chk("up_cnt_dec", mapBackgroundCnt, 0);
        drain();
        sb_mute = 1'b1;
        for (int i = 0; i < 239; i++) frame(3);
        sb_mute = 1'b0;
        chk("up_bulk_ptr", mapScrollPtr, 239);
        expect_req(1'b0, S, 9'd256);
        expect_req(1'b1, S + 24'd960, 9'd496);
        frame(3);
        chk("up_half_ptr", mapScrollPtr, 0);
        chk("up_half_ptrout", scrollPtrOut, 239);
        chk("up_cnt_sat", mapBackgroundCnt, 0);
        drain();

        // Background limit: stop (or loop) once the count passes mapBackgroundMax
        mapBackgroundMax = 8'd1;
        scrollDir = 1'b0;
        sb_mute = 1'b1;
        frame(3);
        chk("lim_ptr1", mapScrollPtr, 239);
        chk("lim_cnt1", mapBackgroundCnt, 1);
        chk("lim_flag1", scrollingFlag, 1);
        for (int i = 0; i < 240; i++) frame(3);
`ifdef SCROLL_LOOP_EN
        chk("lim_cnt2", mapBackgroundCnt, 0);
        chk("lim_flag2", scrollingFlag, 1);
        frame(3);
        chk("lim_after", mapScrollPtr, 238);
`else
        chk("lim_cnt2", mapBackgroundCnt, 2);
        chk("lim_flag2", scrollingFlag, 0);
        frame(3);
        chk("lim_after", mapScrollPtr, 239);
`endif

        // Flush while a request waits on reqReady
        scrollEn = 1'b0; tick(2);
        mapBackgroundMax = 8'd10; scrollDir = 1'b1; reqReady = 1'b0;
        scrollEn = 1'b1; tick(1);
        for (int i = 0; i < 8; i++) frame(3);
        chk("flush_pre_valid", reqValid, 1);
        scrollEn = 1'b0; tick(1);
        chk("flush_valid", reqValid, 0);
        chk("flush_ptr", mapScrollPtr, 0);
        sb_mute = 1'b0;

        // Overrun: three tile rows with the queue blocked
        scrollEn = 1'b1; tick(1);
        expect_req(1'b0, S + 24'd32, 9'd8);
        expect_req(1'b0, S + 24'd64, 9'd16);
        for (int i = 0; i < 8; i++) frame(3);
        chk("ovr_valid", reqValid, 1);
        chk("ovr_err0", overrunErr, 0);
        for (int i = 0; i < 8; i++) frame(3);
        chk("ovr_err1", overrunErr, 0);
        for (int i = 0; i < 8; i++) frame(3);
        chk("ovr_err2", overrunErr, 1);
        reqReady = 1'b1;
        drain();
        tick(2);
        chk("ovr_empty", reqValid, 0);
        chk("ovr_sticky", overrunErr, 1);
        scrollEn = 1'b0; tick(1);
        chk("ovr_clear", overrunErr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, required completion before time limit");
        $fatal(1);
    end

endmodule
